fwd_hazard_scoreboard: RTL and testbench
========================================

Name: fwd_hazard_scoreboard

Overview:
- Next-generation forwarding/hazard unit for the RV32F pipeline.
- Generalises forwarding to NUM_SRC EX operands, each tagged int or fp register class. Class must match; f0 is forwardable, x0 never is.
- Adds a registered scoreboard for multi-cycle FPU ops (fdiv/fsqrt) and load-use detection, so it produces the ID stall as well as the EX forwarding selects.

Parameters:
NUM_SRC, 3, operand ports per instruction (rs1, rs2, rs3)
RA_W, 5, register address width
MAX_OUT, 4, max in-flight multi-cycle ops (must be >= 1)

Ports:
clk  in  1  pipeline clock
rst_n  in  1  async active-low reset
id_src  in  NUM_SRC*RA_W  ID source addresses; lane i at [i*RA_W +: RA_W]
id_src_fp  in  NUM_SRC  1 = fp class
id_src_used  in  NUM_SRC  lane valid
id_rd, id_rd_fp, id_wen  in  RA_W,1,1  ID destination
id_mc  in  1  ID instruction is multi-cycle
issue  in  1  ID->EX advance; pipeline drives issue = id_valid & ~stall
ex_src, ex_src_fp, ex_src_used  in  NUM_SRC*RA_W, NUM_SRC, NUM_SRC  EX operands
ex_memread, ex_rd, ex_rd_fp  in  1,RA_W,1  EX load destination
mem_wen, mem_rd, mem_fp  in  1,RA_W,1  MEM writer
wb_wen, wb_rd, wb_fp  in  1,RA_W,1  WB writer
mc_done, mc_rd, mc_fp  in  1,RA_W,1  multi-cycle unit regfile write this cycle
fwd_sel  out  2*NUM_SRC  per-lane select: 00 regfile, 10 MEM, 01 WB
stall  out  1  hold ID/IF, bubble EX
outstanding  out  $clog2(MAX_OUT+1)  in-flight multi-cycle count
sb_err  out  1  sticky protocol error

Behaviour:
- Class-aware match(a,afp,b,bfp) = (a==b) & (afp==bfp) & ~(a==0 & ~afp).
- fwd_sel lane i (combinational, ex_src_used[i] gates):
  - 10 if mem_wen & match(MEM)
  - else 01 if wb_wen & match(WB)
  - else 00
  - MEM has priority over WB.
- Scoreboard: busy[2^RA_W] per class (int, fp); int x0 never set.
  - Set at posedge on issue & id_wen & id_mc for (id_rd, id_rd_fp).
  - Cleared at posedge on mc_done for (mc_rd, mc_fp).
  - The regfile is not write-through, so a reader of mc_rd still stalls in the mc_done cycle and proceeds the next cycle.
- stall (combinational from registered busy + inputs), asserted if any of:
  - RAW: a used id_src lane hits busy.
  - WAW: id_wen & busy[id_rd].
  - Load-use: ex_memread & a used id_src lane matches (ex_rd, ex_rd_fp).
  - Capacity: id_mc & outstanding==MAX_OUT & ~mc_done.
  - WB-port conflict: mc_done & id_wen & ~id_mc is not handled here; the mc unit owns the writeback port.
- outstanding at posedge: +1 on multi-cycle issue, -1 on valid mc_done, unchanged on both.
- sb_err sets and holds until reset on any of:
  - mc_done to a non-busy entry; that entry and the counter stay unchanged.
  - issue while stall=1.
  - Counter overflow attempt.
- Simultaneous mc_done and issue to the same register cannot occur, because WAW stalls issue. If forced, set wins and sb_err is raised.
- Reset (async, any cycle including mid-op): busy all 0, outstanding 0, sb_err 0. fwd_sel/stall then follow the inputs (idle inputs give 0).
- Latency: forwarding and stall are zero-cycle combinational; scoreboard updates take one cycle.

Decomposition:
- Shared package/include `fwd_defs`: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, class encodings INT=0/FP=1.
- One sub-module, `fwd_lane_sel`: per-lane priority mux/match, instantiated NUM_SRC times via generate.
- The scoreboard and stall logic stay in the top.

Test Plan:
- mem_wen, mem_rd=5, mem_fp=0; wb_wen, wb_rd=5, wb_fp=0; ex_src lane0=x5 int -> fwd_sel[1:0]=10. Drop mem_wen -> 01.
- mem_rd=0 int, ex_src=x0 -> 00. Same with fp f0 on both -> 10. mem_rd=3 int vs ex lane2 f3 -> 00.
- Issue fdiv f7 (id_mc) -> outstanding=1. Next instr reads f7 -> stall=1 until the cycle after mc_done f7, then 0; outstanding=0.
- ex_memread, ex_rd=x9; id lane1 reads x9 -> stall=1 for exactly one cycle. id reads f9 -> stall=0.
- Issue 4 multi-cycle ops to f1..f4 -> outstanding=4. 5th id_mc -> stall. Same-cycle mc_done f2 -> stall=0, outstanding stays 4.
- mc_done f20 with no pending op -> sb_err=1, outstanding unchanged. Assert rst_n=0 mid-op -> busy cleared, sb_err=0 immediately.

Source files
------------

// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared encodings for the forwarding/hazard unit: forwarding selects and
// register class tags.
package fwd_defs;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      CLS_INT = 1'b0,
      CLS_FP  = 1'b1
   } reg_class_e;

endpackage

// File: rtl/fwd_lane_sel.sv
// One EX operand lane: class-aware match against MEM and WB writers, MEM
// taking priority because it holds the younger result.
module fwd_lane_sel
   import fwd_defs::*;
#(
   parameter int RA_W = 5
) (
   input  logic [RA_W-1:0] src_i,
   input  logic            src_fp_i,
   input  logic            src_used_i,
   input  logic            mem_wen_i,
   input  logic [RA_W-1:0] mem_rd_i,
   input  logic            mem_fp_i,
   input  logic            wb_wen_i,
   input  logic [RA_W-1:0] wb_rd_i,
   input  logic            wb_fp_i,
   output logic [1:0]      sel_o
);

   // x0 is hardwired zero and never forwarded; f0 is an ordinary register.
   function automatic logic regMatch(input logic [RA_W-1:0] a, input logic afp,
                                     input logic [RA_W-1:0] b, input logic bfp);
      return (a == b) && (afp == bfp) && !((a == '0) && (afp == CLS_INT));
   endfunction

   always_comb begin
      sel_o = FWD_RF;
      if (src_used_i) begin
         if (mem_wen_i && regMatch(src_i, src_fp_i, mem_rd_i, mem_fp_i)) begin
            sel_o = FWD_MEM;
         end else if (wb_wen_i && regMatch(src_i, src_fp_i, wb_rd_i, wb_fp_i)) begin
            sel_o = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding selects for the EX operands plus a per-class busy scoreboard for
// multi-cycle FPU ops that, together with load-use detection, drives the ID stall.
module fwd_hazard_scoreboard
   import fwd_defs::*;
#(
   parameter int NUM_SRC = 3,
   parameter int RA_W    = 5,
   parameter int MAX_OUT = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_SRC*RA_W-1:0]       id_src,
   input  logic [NUM_SRC-1:0]            id_src_fp,
   input  logic [NUM_SRC-1:0]            id_src_used,
   input  logic [RA_W-1:0]               id_rd,
   input  logic                          id_rd_fp,
   input  logic                          id_wen,
   input  logic                          id_mc,
   input  logic                          issue,
   input  logic [NUM_SRC*RA_W-1:0]       ex_src,
   input  logic [NUM_SRC-1:0]            ex_src_fp,
   input  logic [NUM_SRC-1:0]            ex_src_used,
   input  logic                          ex_memread,
   input  logic [RA_W-1:0]               ex_rd,
   input  logic                          ex_rd_fp,
   input  logic                          mem_wen,
   input  logic [RA_W-1:0]               mem_rd,
   input  logic                          mem_fp,
   input  logic                          wb_wen,
   input  logic [RA_W-1:0]               wb_rd,
   input  logic                          wb_fp,
   input  logic                          mc_done,
   input  logic [RA_W-1:0]               mc_rd,
   input  logic                          mc_fp,
   output logic [2*NUM_SRC-1:0]          fwd_sel,
   output logic                          stall,
   output logic [$clog2(MAX_OUT+1)-1:0]  outstanding,
   output logic                          sb_err
);

   localparam int NREG = 1 << RA_W;
   localparam int CW   = $clog2(MAX_OUT + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

   logic [NREG-1:0] busyInt_q, busyInt_d, busyFp_q, busyFp_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic            sbErr_q, sbErr_d;
   logic            rawHit, loadUse, wawHit, capHit, full;
   logic            mcIssue, setEn, doneValid, sameRegClash;

   function automatic logic regMatch(input logic [RA_W-1:0] a, input logic afp,
                                     input logic [RA_W-1:0] b, input logic bfp);
      return (a == b) && (afp == bfp) && !((a == '0) && (afp == CLS_INT));
   endfunction

   for (genvar g = 0; g < NUM_SRC; g++) begin : gLane
      fwd_lane_sel #(.RA_W(RA_W)) uLane (
         .src_i      (ex_src[g*RA_W +: RA_W]),
         .src_fp_i   (ex_src_fp[g]),
         .src_used_i (ex_src_used[g]),
         .mem_wen_i  (mem_wen),
         .mem_rd_i   (mem_rd),
         .mem_fp_i   (mem_fp),
         .wb_wen_i   (wb_wen),
         .wb_rd_i    (wb_rd),
         .wb_fp_i    (wb_fp),
         .sel_o      (fwd_sel[2*g +: 2])
      );
   end

   always_comb begin
      rawHit  = 1'b0;
      loadUse = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (id_src_used[i]) begin
            if (id_src_fp[i] ? busyFp_q[id_src[i*RA_W +: RA_W]]
                             : busyInt_q[id_src[i*RA_W +: RA_W]]) begin
               rawHit = 1'b1;
            end
            if (ex_memread && regMatch(id_src[i*RA_W +: RA_W], id_src_fp[i], ex_rd, ex_rd_fp)) begin
               loadUse = 1'b1;
            end
         end
      end
   end

   // A completing op frees a slot in the same cycle, so it lifts the capacity stall.
   assign full   = (outstanding_q == MAX_CNT);
   assign wawHit = id_wen && (id_rd_fp ? busyFp_q[id_rd] : busyInt_q[id_rd]);
   assign capHit = id_mc && full && !mc_done;
   assign stall  = rawHit || wawHit || loadUse || capHit;

   assign mcIssue      = issue && id_mc;
   assign setEn        = mcIssue && id_wen && !((id_rd == '0) && (id_rd_fp == CLS_INT));
   assign doneValid    = mc_done && (mc_fp ? busyFp_q[mc_rd] : busyInt_q[mc_rd]);
   assign sameRegClash = setEn && mc_done && (mc_rd == id_rd) && (mc_fp == id_rd_fp);

   always_comb begin
      busyInt_d     = busyInt_q;
      busyFp_d      = busyFp_q;
      outstanding_d = outstanding_q;
      sbErr_d       = sbErr_q;
      if (doneValid) begin
         if (mc_fp) busyFp_d[mc_rd]  = 1'b0;
         else       busyInt_d[mc_rd] = 1'b0;
      end
      // Set after clear so a forced same-register clash leaves the entry busy.
      if (setEn) begin
         if (id_rd_fp) busyFp_d[id_rd]  = 1'b1;
         else          busyInt_d[id_rd] = 1'b1;
      end
      if (mcIssue && !doneValid && !full) begin
         outstanding_d = outstanding_q + CW'(1);
      end else if (doneValid && !mcIssue) begin
         outstanding_d = outstanding_q - CW'(1);
      end
      if ((mc_done && !doneValid) || (issue && stall) ||
          (mcIssue && !doneValid && full) || sameRegClash) begin
         sbErr_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busyInt_q     <= '0;
         busyFp_q      <= '0;
         outstanding_q <= '0;
         sbErr_q       <= 1'b0;
      end else begin
         busyInt_q     <= busyInt_d;
         busyFp_q      <= busyFp_d;
         outstanding_q <= outstanding_d;
         sbErr_q       <= sbErr_d;
      end
   end

   assign outstanding = outstanding_q;
   assign sb_err      = sbErr_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed and randomized checks of forwarding, stall and scoreboard state
// against a register-array reference model.
module tb_fwd_hazard_scoreboard;

   localparam int NUM_SRC = 3;
   localparam int RA_W    = 5;
   localparam int MAX_OUT = 4;
   localparam int CW      = $clog2(MAX_OUT + 1);

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NUM_SRC*RA_W-1:0] id_src, ex_src;
   logic [NUM_SRC-1:0]      id_src_fp, id_src_used, ex_src_fp, ex_src_used;
   logic [RA_W-1:0]         id_rd, ex_rd, mem_rd, wb_rd, mc_rd;
   logic                    id_rd_fp, id_wen, id_mc, issue, ex_memread, ex_rd_fp;
   logic                    mem_wen, mem_fp, wb_wen, wb_fp, mc_done, mc_fp;
   logic [2*NUM_SRC-1:0]    fwd_sel;
   logic                    stall, sb_err;
   logic [CW-1:0]           outstanding;

   int total = 0;
   int bad   = 0;

   // Reference model: busy flags indexed [class][register], pending op list.
   bit busyM[2][32];
   int outM;
   bit errM;
   int pendRd[$];
   bit pendFp[$];

   fwd_hazard_scoreboard #(.NUM_SRC(NUM_SRC), .RA_W(RA_W), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_src(id_src), .id_src_fp(id_src_fp), .id_src_used(id_src_used),
      .id_rd(id_rd), .id_rd_fp(id_rd_fp), .id_wen(id_wen), .id_mc(id_mc), .issue(issue),
      .ex_src(ex_src), .ex_src_fp(ex_src_fp), .ex_src_used(ex_src_used),
      .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_rd_fp(ex_rd_fp),
      .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_fp(mem_fp),
      .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_fp(wb_fp),
      .mc_done(mc_done), .mc_rd(mc_rd), .mc_fp(mc_fp),
      .fwd_sel(fwd_sel), .stall(stall), .outstanding(outstanding), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   function automatic bit mt(int a, bit afp, int b, bit bfp);
      return (a == b) && (afp == bfp) && !(a == 0 && !afp);
   endfunction

   function automatic logic [1:0] expLaneSel(int i);
      int s;
      bit f;
      s = int'(ex_src[i*RA_W +: RA_W]);
      f = ex_src_fp[i];
      if (!ex_src_used[i]) return 2'b00;
      if (mem_wen && mt(s, f, int'(mem_rd), mem_fp)) return 2'b10;
      if (wb_wen && mt(s, f, int'(wb_rd), wb_fp)) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit expStall();
      bit s;
      s = 0;
      for (int i = 0; i < NUM_SRC; i++) begin
         int a;
         bit f;
         a = int'(id_src[i*RA_W +: RA_W]);
         f = id_src_fp[i];
         if (id_src_used[i]) begin
            if (busyM[f][a]) s = 1;
            if (ex_memread && mt(a, f, int'(ex_rd), ex_rd_fp)) s = 1;
         end
      end
      if (id_wen && busyM[id_rd_fp][id_rd]) s = 1;
      if (id_mc && outM == MAX_OUT && !mc_done) s = 1;
      return s;
   endfunction

   task automatic checkVal(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(string tag);
      logic [2*NUM_SRC-1:0] e;
      for (int i = 0; i < NUM_SRC; i++) e[2*i +: 2] = expLaneSel(i);
      checkVal({tag, ".fwd_sel"}, 32'(fwd_sel), 32'(e));
      checkVal({tag, ".stall"}, 32'(stall), 32'(expStall()));
   endtask

   task automatic checkState(string tag);
      checkVal({tag, ".outstanding"}, 32'(outstanding), 32'(outM));
      checkVal({tag, ".sb_err"}, 32'(sb_err), 32'(errM));
   endtask

   task automatic modelReset();
      foreach (busyM[c, r]) busyM[c][r] = 0;
      outM = 0;
      errM = 0;
      pendRd.delete();
      pendFp.delete();
   endtask

   task automatic idle();
      id_src = '0; id_src_fp = '0; id_src_used = '0;
      id_rd = '0; id_rd_fp = 0; id_wen = 0; id_mc = 0; issue = 0;
      ex_src = '0; ex_src_fp = '0; ex_src_used = '0;
      ex_memread = 0; ex_rd = '0; ex_rd_fp = 0;
      mem_wen = 0; mem_rd = '0; mem_fp = 0;
      wb_wen = 0; wb_rd = '0; wb_fp = 0;
      mc_done = 0; mc_rd = '0; mc_fp = 0;
   endtask

   task automatic setId(int lane, int r, bit f);
      id_src[lane*RA_W +: RA_W] = RA_W'(r);
      id_src_fp[lane] = f;
      id_src_used[lane] = 1;
   endtask

   task automatic setEx(int lane, int r, bit f);
      ex_src[lane*RA_W +: RA_W] = RA_W'(r);
      ex_src_fp[lane] = f;
      ex_src_used[lane] = 1;
   endtask

   task automatic mcIssue(int r, bit f);
      idle();
      id_rd = RA_W'(r); id_rd_fp = f; id_wen = 1; id_mc = 1; issue = 1;
   endtask

   // Called just after a negedge with inputs set; checks combinational outputs,
   // clocks once, advances the model and checks the registered state.
   task automatic applyStimulus(string tag);
      bit stallNow, done, mcIss, setE, errNow;
      #2;
      checkOutput(tag);
      @(posedge clk);
      stallNow = expStall();
      done  = mc_done && busyM[mc_fp][mc_rd];
      mcIss = issue && id_mc;
      setE  = mcIss && id_wen && !(id_rd == 0 && !id_rd_fp);
      errNow = (mc_done && !done) || (issue && stallNow) ||
               (mcIss && !done && outM == MAX_OUT) ||
               (setE && mc_done && mc_rd == id_rd && mc_fp == id_rd_fp);
      if (done) begin
         busyM[mc_fp][mc_rd] = 0;
         for (int k = 0; k < pendRd.size(); k++) begin
            if (pendRd[k] == int'(mc_rd) && pendFp[k] == mc_fp) begin
               pendRd.delete(k);
               pendFp.delete(k);
               break;
            end
         end
      end
      if (setE) begin
         busyM[id_rd_fp][id_rd] = 1;
         pendRd.push_back(int'(id_rd));
         pendFp.push_back(id_rd_fp);
      end
      if (mcIss && !done) begin
         if (outM < MAX_OUT) outM++;
      end else if (done && !mcIss) begin
         outM--;
      end
      if (errNow) errM = 1;
      #1;
      checkState(tag);
      @(negedge clk);
   endtask

   task automatic drain(string tag);
      for (int n = 0; n < 40; n++) begin
         if (pendRd.size() == 0) break;
         idle();
         mc_done = 1; mc_rd = RA_W'(pendRd[0]); mc_fp = pendFp[0];
         applyStimulus(tag);
      end
      idle();
   endtask

   initial begin
      rst_n = 0;
      idle();
      modelReset();
      #3;
      checkVal("reset.outstanding", 32'(outstanding), 0);
      checkVal("reset.sb_err", 32'(sb_err), 0);
      checkVal("reset.stall", 32'(stall), 0);
      checkVal("reset.fwd_sel", 32'(fwd_sel), 0);
      @(negedge clk);
      rst_n = 1;

      // MEM beats WB for the same register, WB used once MEM drops out
      idle();
      mem_wen = 1; mem_rd = 5; wb_wen = 1; wb_rd = 5; setEx(0, 5, 0);
      #1 checkVal("mem_prio", 32'(fwd_sel[1:0]), 32'h2);
      applyStimulus("mem_prio");
      mem_wen = 0;
      #1 checkVal("wb_only", 32'(fwd_sel[1:0]), 32'h1);
      applyStimulus("wb_only");

      // x0 never forwards, f0 does, class mismatch does not
      idle();
      mem_wen = 1; mem_rd = 0; setEx(0, 0, 0);
      #1 checkVal("x0_nofwd", 32'(fwd_sel[1:0]), 0);
      applyStimulus("x0_nofwd");
      mem_fp = 1; ex_src_fp[0] = 1;
      #1 checkVal("f0_fwd", 32'(fwd_sel[1:0]), 32'h2);
      applyStimulus("f0_fwd");
      idle();
      mem_wen = 1; mem_rd = 3; setEx(2, 3, 1);
      #1 checkVal("class_mismatch", 32'(fwd_sel[5:4]), 0);
      applyStimulus("class_mismatch");

      // fdiv f7 then a reader of f7 waits until the cycle after mc_done
      mcIssue(7, 1);
      applyStimulus("fdiv_issue");
      checkVal("fdiv_out", 32'(outstanding), 1);
      idle();
      setId(0, 7, 1);
      #1 checkVal("raw_f7_stall", 32'(stall), 1);
      repeat (2) applyStimulus("raw_f7_wait");
      mc_done = 1; mc_rd = 7; mc_fp = 1;
      #1 checkVal("raw_f7_done_cycle", 32'(stall), 1);
      applyStimulus("raw_f7_done");
      mc_done = 0;
      #1 checkVal("raw_f7_release", 32'(stall), 0);
      checkVal("raw_f7_out", 32'(outstanding), 0);
      issue = 1;
      applyStimulus("raw_f7_issue");

      // load-use on x9 for one cycle, f9 unaffected
      idle();
      ex_memread = 1; ex_rd = 9; setId(1, 9, 0);
      #1 checkVal("load_use", 32'(stall), 1);
      applyStimulus("load_use");
      ex_memread = 0; issue = 1;
      #1 checkVal("load_use_clear", 32'(stall), 0);
      applyStimulus("load_use_clear");
      idle();
      ex_memread = 1; ex_rd = 9; setId(1, 9, 1);
      #1 checkVal("load_use_fp", 32'(stall), 0);
      applyStimulus("load_use_fp");

      // fill to capacity, then a same-cycle completion makes room
      for (int k = 1; k <= 4; k++) begin
         mcIssue(k, 1);
         applyStimulus("fill");
      end
      checkVal("cap_full", 32'(outstanding), 4);
      idle();
      id_rd = 5; id_rd_fp = 1; id_wen = 1; id_mc = 1;
      #1 checkVal("cap_stall", 32'(stall), 1);
      applyStimulus("cap_stall");
      mc_done = 1; mc_rd = 2; mc_fp = 1;
      #1 checkVal("cap_room", 32'(stall), 0);
      issue = 1;
      applyStimulus("cap_swap");
      checkVal("cap_swap_out", 32'(outstanding), 4);
      drain("drain1");
      checkVal("drain1_out", 32'(outstanding), 0);

      // randomized legal traffic
      for (int n = 0; n < 400; n++) begin
         idle();
         for (int i = 0; i < NUM_SRC; i++) begin
            if ($urandom_range(0, 1) == 1) setId(i, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) setEx(i, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         end
         ex_memread = ($urandom_range(0, 3) == 0);
         ex_rd = RA_W'($urandom_range(0, 7)); ex_rd_fp = 1'($urandom_range(0, 1));
         mem_wen = 1'($urandom_range(0, 1)); mem_rd = RA_W'($urandom_range(0, 7)); mem_fp = 1'($urandom_range(0, 1));
         wb_wen = 1'($urandom_range(0, 1)); wb_rd = RA_W'($urandom_range(0, 7)); wb_fp = 1'($urandom_range(0, 1));
         id_mc = ($urandom_range(0, 3) == 0);
         id_rd_fp = 1'($urandom_range(0, 1));
         if (id_mc) begin
            id_wen = 1; id_rd = RA_W'($urandom_range(1, 7));
         end else begin
            id_wen = 1'($urandom_range(0, 1)); id_rd = RA_W'($urandom_range(0, 7));
         end
         if (pendRd.size() > 0 && $urandom_range(0, 2) == 0) begin
            int k;
            k = int'($urandom_range(0, pendRd.size() - 1));
            mc_done = 1; mc_rd = RA_W'(pendRd[k]); mc_fp = pendFp[k];
         end else begin
            mc_rd = RA_W'($urandom_range(0, 31)); mc_fp = 1'($urandom_range(0, 1));
         end
         issue = ($urandom_range(0, 3) != 0) && !expStall();
         applyStimulus("rand");
      end
      drain("drain2");
      checkVal("rand_out", 32'(outstanding), 0);
      checkVal("rand_err", 32'(sb_err), 0);

      // completion for an idle register is a protocol error
      idle();
      mc_done = 1; mc_rd = 20; mc_fp = 1;
      applyStimulus("bogus_done");
      checkVal("bogus_err", 32'(sb_err), 1);
      checkVal("bogus_out", 32'(outstanding), 0);

      // asynchronous reset in the middle of an op
      mcIssue(6, 1);
      applyStimulus("pre_reset");
      idle();
      setId(0, 6, 1);
      #1 checkVal("pre_reset_stall", 32'(stall), 1);
      #2 rst_n = 0;
      #1;
      checkVal("async_out", 32'(outstanding), 0);
      checkVal("async_err", 32'(sb_err), 0);
      checkVal("async_stall", 32'(stall), 0);
      modelReset();
      @(negedge clk);
      rst_n = 1;
      applyStimulus("post_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
